fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 41 ++++
 rtl/fetch_stage_npc_calc.sv | 32 +++
 rtl/fetch_stage.sv | 53 +++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared MIPS encoding constants and the D-stage control-flow decode
// used by the fetch stage and the hazard unit.
package fetch_stage_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;

    localparam logic [5:0] FUNCT_JR  = 6'b001000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_RESET_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTRL_SEQ,
        CTRL_BEQ,
        CTRL_JUMP,
        CTRL_JR
    } ctrl_e;

    // j and jal redirect identically here; the link write happens downstream.
    function automatic ctrl_e decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_e ctrl;
        ctrl = CTRL_SEQ;
        case (opcode)
            OP_BEQ:       ctrl = CTRL_BEQ;
            OP_J, OP_JAL: ctrl = CTRL_JUMP;
            OP_R:         ctrl = (funct == FUNCT_JR) ? CTRL_JR : CTRL_SEQ;
            default:      ctrl = CTRL_SEQ;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection from the instruction currently in D.
// Priority: jr, then j/jal, then taken beq, else sequential pc_f + 4.
module npc_calc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    input  logic        cmp_eq_d,
    input  logic [31:0] rs_value_d,
    output logic [31:0] npc
);

    logic [31:0] pc_d_plus4;
    logic [31:0] branch_off;
    ctrl_e       ctrl;

    assign pc_d_plus4 = pc_d + 32'd4;
    assign branch_off = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign ctrl       = decode_ctrl(instr_d[31:26], instr_d[5:0]);

    always_comb begin
        npc = pc_f + 32'd4;
        case (ctrl)
            CTRL_JR:   npc = rs_value_d;
            CTRL_JUMP: npc = {pc_d_plus4[31:28], instr_d[25:0], 2'b00};
            CTRL_BEQ:  if (cmp_eq_d) npc = pc_d_plus4 + branch_off;
            default:   npc = pc_f + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS F stage: PC register, instruction-memory address, and IF/ID register.
// Branches use delayed-slot semantics, so nothing in F is ever flushed.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] RESET_INSTR = DEFAULT_RESET_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        if_id_en,
    input  logic        cmp_eq_d,
    input  logic [31:0] rs_value_d,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d
);

    logic [31:0] npc;

    npc_calc u_npc_calc (
        .pc_f       (pc_f),
        .pc_d       (pc_d),
        .instr_d    (instr_d),
        .cmp_eq_d   (cmp_eq_d),
        .rs_value_d (rs_value_d),
        .npc        (npc)
    );

    assign imem_addr = pc_f;

    // During a stall npc keeps tracking the held instr_d, so late forwarded
    // operands are picked up on the first cycle pc_write rises again.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            instr_d <= RESET_INSTR;
            pc_d    <= 32'h0;
        end else begin
            if (pc_write) begin
                pc_f <= npc;
            end
            if (if_id_en) begin
                instr_d <= imem_rdata;
                pc_d    <= pc_f;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        if_id_en;
    logic        cmp_eq_d;
    logic [31:0] rs_value_d;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;

    logic [31:0] mem [0:255];
    logic [31:0] m_pc, m_instr, m_pcd;
    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] BEQ_FWD3  = 32'h1022_0003;
    localparam logic [31:0] BEQ_BACK1 = 32'h1022_FFFF;
    localparam logic [31:0] J_C03     = 32'h0800_0C03;
    localparam logic [31:0] JAL_C03   = 32'h0C00_0C03;
    localparam logic [31:0] JR_R1     = 32'h0020_0008;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pc_write   (pc_write),
        .if_id_en   (if_id_en),
        .cmp_eq_d   (cmp_eq_d),
        .rs_value_d (rs_value_d),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d)
    );

    // Clock and combinational instruction memory (1 KiB window, word indexed).
    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr[9:2]];

    function automatic logic [31:0] mem_at(input logic [31:0] addr);
        return mem[addr[9:2]];
    endfunction

    // Reference next-PC, straight from the control-flow rules.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] instr,
                                            input logic [31:0] pcd, input logic cmp,
                                            input logic [31:0] rs);
        int unsigned op, funct, idx;
        int          imm;
        op    = instr[31:26];
        funct = instr[5:0];
        idx   = instr[25:0];
        imm   = int'($signed(instr[15:0]));
        if (op == 0 && funct == 8) return rs;
        if (op == 2 || op == 3)    return ((pcd + 32'd4) & 32'hF000_0000) | (idx * 4);
        if (op == 4 && cmp)        return pcd + 32'd4 + 32'(imm * 4);
        return pc + 32'd4;
    endfunction

    // Driver: advance one clock, updating the model alongside the DUT.
    task automatic tick();
        logic [31:0] nxt;
        nxt = ref_npc(m_pc, m_instr, m_pcd, cmp_eq_d, rs_value_d);
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0000_3000; m_instr = 32'h0; m_pcd = 32'h0;
        end else begin
            if (if_id_en) begin
                m_instr = mem_at(m_pc);
                m_pcd   = m_pc;
            end
            if (pc_write) m_pc = nxt;
        end
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h3400_0000 | 32'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1; pc_write = 1'b1; if_id_en = 1'b1; cmp_eq_d = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        rs_value_d = 32'h0;
        do_reset();
        total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_f, 32'h3000); end
        total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_d, 32'h0); end
        total++; if (pc_d !== 32'h0) begin bad++; $display("FAIL reset_pcd got=%h exp=%h", pc_d, 32'h0); end
    endtask

    task automatic test_sequential();
        logic [31:0] e, prev;
        clear_mem();
        do_reset();
        exp_q = {};
        exp_q.push_back(32'h3000); exp_q.push_back(32'h3004); exp_q.push_back(32'h3008);
        prev = 32'hx;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            total++; if (pc_f !== e) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_f, e); end
            if (i > 0) begin
                total++; if (pc_d !== prev) begin bad++; $display("FAIL seq_pcd[%0d] got=%h exp=%h", i, pc_d, prev); end
                total++; if (instr_d !== mem_at(prev)) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, instr_d, mem_at(prev)); end
            end
            prev = e;
            tick();
        end
    endtask

    task automatic test_beq();
        // taken forward
        clear_mem(); mem[0] = BEQ_FWD3;
        do_reset(); tick();
        cmp_eq_d = 1'b1; tick(); cmp_eq_d = 1'b0;
        total++; if (pc_f !== 32'h3010) begin bad++; $display("FAIL beq_taken_pc got=%h exp=%h", pc_f, 32'h3010); end
        total++; if (instr_d !== mem[1]) begin bad++; $display("FAIL beq_slot_instr got=%h exp=%h", instr_d, mem[1]); end
        total++; if (pc_d !== 32'h3004) begin bad++; $display("FAIL beq_slot_pcd got=%h exp=%h", pc_d, 32'h3004); end
        // not taken
        do_reset(); tick();
        cmp_eq_d = 1'b0; tick();
        total++; if (pc_f !== 32'h3008) begin bad++; $display("FAIL beq_nt_pc got=%h exp=%h", pc_f, 32'h3008); end
        // backward, taken at pc_d 0x3008
        clear_mem(); mem[2] = BEQ_BACK1;
        do_reset(); tick(); tick(); tick();
        total++; if (pc_d !== 32'h3008) begin bad++; $display("FAIL beq_back_pcd got=%h exp=%h", pc_d, 32'h3008); end
        cmp_eq_d = 1'b1; tick(); cmp_eq_d = 1'b0;
        total++; if (pc_f !== 32'h3008) begin bad++; $display("FAIL beq_back_pc got=%h exp=%h", pc_f, 32'h3008); end
    endtask

    task automatic test_jumps();
        logic [31:0] words [2];
        words[0] = J_C03; words[1] = JAL_C03;
        for (int k = 0; k < 2; k++) begin
            clear_mem(); mem[0] = words[k];
            do_reset(); tick();
            total++; if (pc_f !== 32'h3004) begin bad++; $display("FAIL jump%0d_slot_pc got=%h exp=%h", k, pc_f, 32'h3004); end
            tick();
            total++; if (pc_f !== 32'h300C) begin bad++; $display("FAIL jump%0d_target got=%h exp=%h", k, pc_f, 32'h300C); end
            total++; if (instr_d !== mem[1]) begin bad++; $display("FAIL jump%0d_slot_instr got=%h exp=%h", k, instr_d, mem[1]); end
        end
        clear_mem(); mem[0] = JR_R1;
        do_reset(); tick();
        rs_value_d = 32'h3020; tick();
        total++; if (pc_f !== 32'h3020) begin bad++; $display("FAIL jr_target got=%h exp=%h", pc_f, 32'h3020); end
    endtask

    task automatic test_stall();
        clear_mem(); mem[0] = BEQ_FWD3;
        do_reset(); tick();
        pc_write = 1'b0; if_id_en = 1'b0; cmp_eq_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (pc_f !== 32'h3004) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc_f, 32'h3004); end
            total++; if (instr_d !== BEQ_FWD3) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, instr_d, BEQ_FWD3); end
            total++; if (pc_d !== 32'h3000) begin bad++; $display("FAIL stall_pcd[%0d] got=%h exp=%h", i, pc_d, 32'h3000); end
            cmp_eq_d = 1'b1;
        end
        pc_write = 1'b1; if_id_en = 1'b1; tick(); cmp_eq_d = 1'b0;
        total++; if (pc_f !== 32'h3010) begin bad++; $display("FAIL stall_release_pc got=%h exp=%h", pc_f, 32'h3010); end
        total++; if (instr_d !== mem[1]) begin bad++; $display("FAIL stall_release_instr got=%h exp=%h", instr_d, mem[1]); end
    endtask

    task automatic test_reset_mid();
        clear_mem(); mem[0] = JR_R1;
        do_reset(); tick();
        rs_value_d = 32'h0000_3100; pc_write = 1'b0; if_id_en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; pc_write = 1'b1; if_id_en = 1'b1;
        total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL midreset_pc got=%h exp=%h", pc_f, 32'h3000); end
        total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL midreset_instr got=%h exp=%h", instr_d, 32'h0); end
        total++; if (pc_d !== 32'h0) begin bad++; $display("FAIL midreset_pcd got=%h exp=%h", pc_d, 32'h0); end
    endtask

    task automatic test_random();
        int unsigned kind;
        for (int i = 0; i < 256; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1: mem[i] = {6'b000100, 10'($urandom), 16'($urandom_range(0, 15) - 8)};
                2:    mem[i] = {6'b000010, 26'h0000C00 | 26'($urandom_range(0, 255))};
                3:    mem[i] = {6'b000011, 26'h0000C00 | 26'($urandom_range(0, 255))};
                4:    mem[i] = JR_R1;
                default: mem[i] = {6'b001101, 26'($urandom)};
            endcase
        end
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            pc_write = ($urandom_range(0, 3) != 0);
            if_id_en = ($urandom_range(0, 7) == 0) ? ~pc_write : pc_write;
            cmp_eq_d = 1'($urandom);
            rs_value_d = 32'h3000 | (32'($urandom_range(0, 255)) << 2);
            tick();
            total++; if (pc_f !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", c, pc_f, m_pc); end
            total++; if (instr_d !== m_instr) begin bad++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", c, instr_d, m_instr); end
            total++; if (pc_d !== m_pcd) begin bad++; $display("FAIL rnd_pcd[%0d] got=%h exp=%h", c, pc_d, m_pcd); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pc_write = 1'b0; if_id_en = 1'b0; cmp_eq_d = 1'b0; rs_value_d = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_beq();
        test_jumps();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
